lsu_ram_ctrl: RTL
=================

# lsu_ram_ctrl

Load/store controller between the core's memory-stage request port and the single-port `Memoria_RAM` (32-bit words, 6-bit word address, whole-word write enable). Accepts byte, halfword and word loads and stores on a byte address and drives the RAM's `addra/dina/wea`. Returns sign- or zero-extended load data. Since the RAM has no byte enables, sub-word stores are performed as read-modify-write.

## Interface
Parameters:
- `ADDR_W`, 6, RAM word-address width; byte address is `ADDR_W+2` bits.
- `DATA_W`, 32, word width; only 32 is supported.

Ports:
- `clka` in 1: single clock for the block and the RAM.
- `rsta` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request; high only in IDLE.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word; 11 is treated as word.
- `req_signed` in 1: sign-extend on loads; ignored for stores.
- `req_addr` in `ADDR_W+2`: byte address.
- `req_wdata` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `rsp_valid` out 1: one-cycle completion pulse; the consumer cannot stall it.
- `rsp_rdata` out 32: load result; 0 for stores and errors.
- `rsp_err` out 1: misaligned access, qualified by `rsp_valid`.
- `ram_addra` out `ADDR_W`: equals `req_addr[ADDR_W+1:2]` of the latched request.
- `ram_dina` out 32: RAM write data.
- `ram_wea` out 1: RAM write enable.
- `ram_douta` in 32: RAM read data; valid one cycle after `ram_addra` is sampled.

## Operation
- Handshake: a request is accepted on a rising edge where `req_valid && req_ready`. All request fields are latched at that edge; the inputs are don't-care afterwards.
- Byte lanes are little-endian:
  - Byte lane is `addr[1:0]`.
  - Half lane is `addr[1]`: 0 selects [15:0], 1 selects [31:16].
- Misaligned means half with `addr[0]=1`, or word with `addr[1:0]!=0`. A misaligned request makes no RAM access and produces `rsp_err=1` with `rsp_rdata=0`.
- FSM states: IDLE, RD, CAP, WR, RSP.
  - Load: IDLE → RD → CAP → RSP → IDLE.
  - Word store: IDLE → WR → RSP → IDLE.
  - Sub-word store: IDLE → RD → CAP → WR → RSP → IDLE.
  - Misaligned: IDLE → RSP → IDLE.
- RD: drive `ram_addra`, `ram_wea=0`.
- CAP: latch `ram_douta` into the internal `word_q` register.
- WR: `ram_wea=1`. `ram_dina` is `req_wdata` for a word store, or `word_q` with only the addressed lane replaced for a sub-word store.
- RSP: `rsp_valid=1`. For loads, `rsp_rdata` is the addressed lane of `word_q`, extended to 32 bits according to `req_signed`.
- Outputs outside their states: `ram_wea=0`, `ram_dina=0`; `ram_addra` holds the last latched value.

## Timing
- Reset values: state IDLE, `req_ready=1`, `rsp_valid=0`, `rsp_rdata=0`, `rsp_err=0`, `ram_wea=0`, `ram_addra=0`, `ram_dina=0`, `word_q=0`.
- `ram_wea` is gated by `!rsta` combinationally, so no RAM write occurs in any reset cycle. Reset in any state abandons the operation and produces no `rsp_valid`.
- Latency, counted from the accepting edge E to the cycle with `rsp_valid` high:
  - Misaligned: E+1.
  - Word store: E+2.
  - Load: E+3.
  - Sub-word store: E+4.
- `req_ready` is low from E until RSP ends. The next request can be accepted at the edge that ends RSP. Maximum throughput is one request per (latency+1) cycles.
- A RAM write commits at the edge that ends WR. A load issued back-to-back after a store returns the new data.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: misaligned detection and `rsp_err` behave as described above.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - Low address bits are masked instead: half ignores `addr[0]`, word ignores `addr[1:0]`.
  - The access proceeds as aligned.
  - `rsp_err` is tied to 0.

## Structure
- Package `lsu_pkg`:
  - `size_t` enum (BYTE, HALF, WORD).
  - `state_t` enum (IDLE, RD, CAP, WR, RSP).
  - Constant `DATA_W=32`.
- Sub-module `lsu_lane_align` (combinational):
  - Extract plus sign/zero extension for loads.
  - Lane merge for store data.
- The FSM and registers stay in `lsu_ram_ctrl`.

## Test plan
- Word store then word load: store addr 0x04 data 0xDEADBEEF → `ram_wea` at E+1 with `ram_addra=1`. The following load of 0x04 gives `rsp_rdata=0xDEADBEEF` at E+3.
- Byte store RMW: word 2 = 0x11223344, store byte 0xAA to addr 0x09 → exactly one write, of 0x1122AA44, at E+3, with `rsp_valid` at E+4.
- Signed/unsigned loads from word 0x8000FF80:
  - Byte at lane 0 with `req_signed=1` → 0xFFFFFF80.
  - Byte at lane 0 with `req_signed=0` → 0x00000080.
  - Half at lane 1 with `req_signed=1` → 0xFFFF8000.
- Misaligned word load at 0x06:
  - With the macro: `rsp_err=1`, `rsp_rdata=0` at E+1, no `ram_wea`.
  - Without the macro: reads word 1.
- Reset during the CAP state of a half store → no `ram_wea`, no `rsp_valid`, and `req_ready=1` in the cycle after `rsta` falls. RAM contents are unchanged.
- Fill all 64 words with 0..63 using word stores, then read back all 64 → each response matches. The address wraps from 63 to 0 without error.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access sizes, controller states and
// the size decode / alignment helpers.
package lsu_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } size_t;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CAP,
    WR,
    RSP
  } state_t;

  // The unused 2'b11 encoding behaves as a word access.
  function automatic size_t decodeSize(input logic [1:0] sz);
    case (sz)
      2'b00:   return BYTE;
      2'b01:   return HALF;
      default: return WORD;
    endcase
  endfunction

  function automatic logic isMisaligned(input size_t sz, input logic [1:0] lane);
    case (sz)
      HALF:    return lane[0];
      WORD:    return lane != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for the LSU: extracts and extends load data, and merges
// sub-word store data into a previously read word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  size_t                   size,
  input  logic  [1:0]             lane,
  input  logic                    sgn,
  input  logic  [DATA_W-1:0]      word,
  input  logic  [DATA_W-1:0]      wdata,
  output logic  [DATA_W-1:0]      loadData,
  output logic  [DATA_W-1:0]      mergeData
);

  logic [3:0][7:0] wordBytes;
  logic [7:0]      selByte;
  logic [15:0]     selHalf;

  assign wordBytes = word;

  always_comb begin
    selByte = wordBytes[lane];
    selHalf = lane[1] ? word[31:16] : word[15:0];
    case (size)
      BYTE:    loadData = {{24{sgn & selByte[7]}}, selByte};
      HALF:    loadData = {{16{sgn & selHalf[15]}}, selHalf};
      default: loadData = word;
    endcase
  end

  // Each byte lane either keeps the old word byte or takes the matching store byte.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic       laneHit;
      logic [7:0] srcByte;

      always_comb begin
        laneHit = 1'b1;
        srcByte = wdata[8*gi +: 8];
        case (size)
          BYTE: begin
            laneHit = (lane == LANE);
            srcByte = wdata[7:0];
          end
          HALF: begin
            laneHit = (lane[1] == LANE[1]);
            srcByte = wdata[8*(gi%2) +: 8];
          end
          default: ;
        endcase
      end

      assign mergeData[8*gi +: 8] = laneHit ? srcByte : word[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/lsu_ram_ctrl.sv
// Load/store controller for a single-port word RAM; sub-word stores are done as
// read-modify-write. Define LSU_MISALIGN_TRAP_EN to report misaligned accesses.
module lsu_ram_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic                clka,
  input  logic                rsta,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_signed,
  input  logic [ADDR_W+1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic [ADDR_W-1:0]   ram_addra,
  output logic [DATA_W-1:0]   ram_dina,
  output logic                ram_wea,
  input  logic [DATA_W-1:0]   ram_douta
);

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  state_t              stateReg;
  size_t               sizeReg;
  logic [1:0]          laneReg;
  logic                signedReg;
  logic                weReg;
  logic                weaReg;
  logic [ADDR_W-1:0]   addrReg;
  logic [DATA_W-1:0]   wdataReg;
  logic [DATA_W-1:0]   word_q;
  logic [DATA_W-1:0]   loadData;
  logic [DATA_W-1:0]   mergeData;
  size_t               reqSize;
  logic                reqMisaligned;

  // Without the trap the lane logic already ignores the low bits a size does not use.
  assign reqSize       = decodeSize(req_size);
  assign reqMisaligned = TRAP_EN && isMisaligned(reqSize, req_addr[1:0]);

  lsu_lane_align u_align (
    .size      (sizeReg),
    .lane      (laneReg),
    .sgn       (signedReg),
    .word      (word_q),
    .wdata     (wdataReg),
    .loadData  (loadData),
    .mergeData (mergeData)
  );

  always_ff @(posedge clka) begin
    if (rsta) begin
      stateReg  <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      weaReg    <= 1'b0;
      addrReg   <= '0;
      word_q    <= '0;
      sizeReg   <= WORD;
      laneReg   <= 2'b00;
      signedReg <= 1'b0;
      weReg     <= 1'b0;
      wdataReg  <= '0;
    end else begin
      case (stateReg)
        IDLE: begin
          if (req_valid && req_ready) begin
            addrReg   <= req_addr[ADDR_W+1:2];
            sizeReg   <= reqSize;
            laneReg   <= req_addr[1:0];
            signedReg <= req_signed;
            weReg     <= req_we;
            wdataReg  <= req_wdata;
            req_ready <= 1'b0;
            if (reqMisaligned) begin
              stateReg  <= RSP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else if (req_we && reqSize == WORD) begin
              stateReg <= WR;
              weaReg   <= 1'b1;
            end else begin
              stateReg <= RD;
            end
          end
        end
        RD: stateReg <= CAP;
        CAP: begin
          word_q <= ram_douta;
          if (weReg) begin
            stateReg <= WR;
            weaReg   <= 1'b1;
          end else begin
            stateReg  <= RSP;
            rsp_valid <= 1'b1;
          end
        end
        WR: begin
          weaReg    <= 1'b0;
          stateReg  <= RSP;
          rsp_valid <= 1'b1;
        end
        RSP: begin
          stateReg  <= IDLE;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          req_ready <= 1'b1;
        end
        default: stateReg <= IDLE;
      endcase
    end
  end

  // A word store has every lane hit, so the merge path also carries full-word data.
  assign ram_wea   = weaReg && !rsta;
  assign ram_dina  = weaReg ? mergeData : '0;
  assign ram_addra = addrReg;
  assign rsp_rdata = (rsp_valid && !weReg && !rsp_err) ? loadData : '0;

endmodule
